// File: rtl/adc_fifo_writer.sv
// ADC acquisition front end: skips a blanking window after start, decimates the
// valid sample stream and writes a fixed number of sample slots into the sample FIFO.
module adc_fifo_writer #(
  parameter int DATA_W = 12,
  parameter int LEN_W  = 20
) (
  input  logic              clk_50M,
  input  logic              rst_n,
  input  logic              sys_start_pulse,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic [15:0]       blank_len,
  input  logic [LEN_W-1:0]  capture_len,
  input  logic [2:0]        decim,
  input  logic              fifo_wrfull,
  output logic [DATA_W-1:0] fifo_data,
  output logic              fifo_wrreq,
  output logic              busy,
  output logic              capture_done,
  output logic [LEN_W-1:0]  sample_cnt,
  output logic [15:0]       overflow_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_CAPTURE, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [15:0]       blank_len_q, blank_len_d;
  logic [15:0]       blank_cnt_q, blank_cnt_d;
  logic [LEN_W-1:0]  capture_len_q, capture_len_d;
  logic [LEN_W-1:0]  sample_cnt_q, sample_cnt_d;
  logic [2:0]        decim_q, decim_d;
  logic [2:0]        phase_q, phase_d;
  logic [15:0]       overflow_cnt_q, overflow_cnt_d;
  logic [DATA_W-1:0] fifo_data_q, fifo_data_d;
  logic              fifo_wrreq_q, fifo_wrreq_d;
  logic              keep;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    state_d        = state_q;
    blank_len_d    = blank_len_q;
    blank_cnt_d    = blank_cnt_q;
    capture_len_d  = capture_len_q;
    sample_cnt_d   = sample_cnt_q;
    decim_d        = decim_q;
    phase_d        = phase_q;
    overflow_cnt_d = overflow_cnt_q;
    fifo_data_d    = fifo_data_q;
    fifo_wrreq_d   = 1'b0;
    keep           = 1'b0;

    // A start in any state aborts the run in progress; its own sample is ignored.
    if (sys_start_pulse) begin
      blank_len_d    = blank_len;
      capture_len_d  = capture_len;
      decim_d        = decim;
      blank_cnt_d    = 16'd0;
      sample_cnt_d   = '0;
      overflow_cnt_d = 16'd0;
      phase_d        = 3'd0;
      state_d        = (blank_len != 16'd0) ? S_BLANK : S_CAPTURE;
    end else begin
      case (state_q)
        S_BLANK: begin
          if (adc_valid) begin
            blank_cnt_d = blank_cnt_q + 16'd1;
            if (blank_cnt_d == blank_len_q) state_d = S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // Completion is judged on the registered count so DONE trails the last write.
          if (sample_cnt_q == capture_len_q) begin
            state_d = S_DONE;
          end else if (adc_valid) begin
            keep    = (phase_q == 3'd0);
            phase_d = (phase_q == decim_q) ? 3'd0 : phase_q + 3'd1;
            if (keep) begin
              sample_cnt_d = sample_cnt_q + LEN_W'(1);
              if (fifo_wrfull) begin
                overflow_cnt_d = sat_inc16(overflow_cnt_q);
              end else begin
                fifo_wrreq_d = 1'b1;
                fifo_data_d  = adc_data;
              end
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      blank_len_q    <= 16'd0;
      blank_cnt_q    <= 16'd0;
      capture_len_q  <= '0;
      sample_cnt_q   <= '0;
      decim_q        <= 3'd0;
      phase_q        <= 3'd0;
      overflow_cnt_q <= 16'd0;
      fifo_data_q    <= '0;
      fifo_wrreq_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      blank_len_q    <= blank_len_d;
      blank_cnt_q    <= blank_cnt_d;
      capture_len_q  <= capture_len_d;
      sample_cnt_q   <= sample_cnt_d;
      decim_q        <= decim_d;
      phase_q        <= phase_d;
      overflow_cnt_q <= overflow_cnt_d;
      fifo_data_q    <= fifo_data_d;
      fifo_wrreq_q   <= fifo_wrreq_d;
    end
  end

  assign fifo_data    = fifo_data_q;
  assign fifo_wrreq   = fifo_wrreq_q;
  assign busy         = (state_q != S_IDLE);
  assign capture_done = (state_q == S_DONE);
  assign sample_cnt   = sample_cnt_q;
  assign overflow_cnt = overflow_cnt_q;

endmodule

// File: tb/tb_adc_fifo_writer.sv
// Directed self-checking bench for adc_fifo_writer: capture, blanking, overflow,
// gapped valid, restart with zero length and asynchronous reset.
module tb_adc_fifo_writer;
  localparam int DATA_W = 12;
  localparam int LEN_W  = 20;

  logic              clk_50M = 1'b0;
  logic              rst_n = 1'b0;
  logic              sys_start_pulse = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic [15:0]       blank_len = '0;
  logic [LEN_W-1:0]  capture_len = '0;
  logic [2:0]        decim = '0;
  logic              fifo_wrfull = 1'b0;
  logic [DATA_W-1:0] fifo_data;
  logic              fifo_wrreq;
  logic              busy;
  logic              capture_done;
  logic [LEN_W-1:0]  sample_cnt;
  logic [15:0]       overflow_cnt;

  int n_checks = 0;
  int n_errors = 0;
  logic [DATA_W-1:0] wr_q[$];
  int done_cnt = 0;

  adc_fifo_writer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .sys_start_pulse(sys_start_pulse),
    .adc_data(adc_data), .adc_valid(adc_valid), .blank_len(blank_len),
    .capture_len(capture_len), .decim(decim), .fifo_wrfull(fifo_wrfull),
    .fifo_data(fifo_data), .fifo_wrreq(fifo_wrreq), .busy(busy),
    .capture_done(capture_done), .sample_cnt(sample_cnt), .overflow_cnt(overflow_cnt)
  );

  always #10 clk_50M = ~clk_50M;

  // Log of every write and done pulse, sampled on the edge that ends each cycle.
  always @(posedge clk_50M) begin
    if (fifo_wrreq) wr_q.push_back(fifo_data);
    if (capture_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic start(input logic [15:0] bl, input logic [LEN_W-1:0] cl, input logic [2:0] dc);
    blank_len       = bl;
    capture_len     = cl;
    decim           = dc;
    sys_start_pulse = 1'b1;
    @(negedge clk_50M);
    sys_start_pulse = 1'b0;
  endtask

  initial begin
    int base_w, base_d, base_w2, nw, nbad, s;
    logic exp_wr;
    logic [DATA_W-1:0] fst, lst;

    // Reset state
    repeat (3) @(negedge clk_50M);
    chk("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(capture_done), 32'd0);
    chk("rst_data", 32'(fifo_data), 32'd0);
    chk("rst_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("rst_overflow_cnt", 32'(overflow_cnt), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_50M);

    // Basic capture: decim=1, 2500 slots of a ramp
    base_w = wr_q.size(); base_d = done_cnt;
    start(16'd0, 20'd2500, 3'd1);
    chk("basic_busy_rise", 32'(busy), 32'd1);
    for (int i = 0; i < 5004; i++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(i);
      @(negedge clk_50M);
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk_50M);
    nw = wr_q.size() - base_w;
    nbad = 0;
    for (int k = 0; k < nw; k++) if (wr_q[base_w + k] !== 12'(2 * k)) nbad++;
    chk("basic_writes", 32'(nw), 32'd2500);
    chk("basic_bad_data", 32'(nbad), 32'd0);
    chk("basic_done_cnt", 32'(done_cnt - base_d), 32'd1);
    chk("basic_overflow", 32'(overflow_cnt), 32'd0);
    chk("basic_sample_cnt", 32'(sample_cnt), 32'd2500);
    chk("basic_busy_fall", 32'(busy), 32'd0);

    // Blanking: first 100 valid samples discarded
    base_w = wr_q.size(); base_d = done_cnt;
    start(16'd100, 20'd10, 3'd0);
    for (int i = 0; i < 115; i++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(i);
      @(negedge clk_50M);
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk_50M);
    nw  = wr_q.size() - base_w;
    fst = (nw > 0) ? wr_q[base_w] : 12'hFFF;
    lst = (nw > 0) ? wr_q[wr_q.size() - 1] : 12'hFFF;
    chk("blank_writes", 32'(nw), 32'd10);
    chk("blank_first", 32'(fst), 32'd100);
    chk("blank_last", 32'(lst), 32'd109);
    chk("blank_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Overflow: FIFO full during slots 5..7
    base_w = wr_q.size(); base_d = done_cnt;
    start(16'd0, 20'd20, 3'd0);
    for (int i = 0; i < 25; i++) begin
      adc_valid   = 1'b1;
      adc_data    = 12'(i);
      fifo_wrfull = (i >= 5) && (i <= 7);
      @(negedge clk_50M);
      if (i == 5)  chk("ovf_slot5_dropped", 32'(fifo_wrreq), 32'd0);
      if (i == 19) chk("ovf_done_not_early", 32'(capture_done), 32'd0);
      if (i == 20) chk("ovf_done_timing", 32'(capture_done), 32'd1);
    end
    adc_valid = 1'b0; fifo_wrfull = 1'b0;
    repeat (4) @(negedge clk_50M);
    nw = wr_q.size() - base_w;
    nbad = 0; s = 0;
    for (int k = 0; k < nw; k++) begin
      if (s == 5) s = 8;
      if (wr_q[base_w + k] !== 12'(s)) nbad++;
      s++;
    end
    chk("ovf_writes", 32'(nw), 32'd17);
    chk("ovf_bad_data", 32'(nbad), 32'd0);
    chk("ovf_overflow_cnt", 32'(overflow_cnt), 32'd3);
    chk("ovf_sample_cnt", 32'(sample_cnt), 32'd20);
    chk("ovf_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Gapped valid: valid 1 in 3 cycles, decim=2
    base_w = wr_q.size(); base_d = done_cnt;
    start(16'd0, 20'd4, 3'd2);
    for (int k = 0; k < 33; k++) begin
      adc_valid = (k % 3 == 0);
      adc_data  = (k % 3 == 0) ? 12'(256 + k / 3) : 12'hFFF;
      @(negedge clk_50M);
      exp_wr = (k % 9 == 0) && (k <= 27);
      chk("gap_wrreq", 32'(fifo_wrreq), 32'(exp_wr));
      if (exp_wr) chk("gap_data", 32'(fifo_data), 32'(256 + k / 3));
    end
    adc_valid = 1'b0;
    repeat (3) @(negedge clk_50M);
    chk("gap_writes", 32'(wr_q.size() - base_w), 32'd4);
    chk("gap_done_cnt", 32'(done_cnt - base_d), 32'd1);

    // Restart mid-capture into a zero-length run with blanking
    base_w = wr_q.size(); base_d = done_cnt;
    adc_valid = 1'b1;
    start(16'd0, 20'd50, 3'd0);
    for (int i = 0; i < 10; i++) begin
      adc_data = 12'(i);
      @(negedge clk_50M);
    end
    start(16'd5, 20'd0, 3'd0);
    base_w2 = wr_q.size();
    chk("rs_first_run_writes", 32'(base_w2 - base_w), 32'd10);
    for (int j = 0; j < 20; j++) begin
      adc_data = 12'(j + 500);
      @(negedge clk_50M);
      if (j == 4) chk("rs_done_not_early", 32'(capture_done), 32'd0);
      if (j == 4) chk("rs_busy", 32'(busy), 32'd1);
      if (j == 5) chk("rs_done_timing", 32'(capture_done), 32'd1);
    end
    adc_valid = 1'b0;
    repeat (2) @(negedge clk_50M);
    chk("rs_second_run_writes", 32'(wr_q.size() - base_w2), 32'd0);
    chk("rs_done_cnt", 32'(done_cnt - base_d), 32'd1);
    chk("rs_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("rs_busy_idle", 32'(busy), 32'd0);

    // Asynchronous reset during capture
    start(16'd0, 20'd100, 3'd0);
    for (int i = 0; i < 10; i++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(i + 40);
      @(negedge clk_50M);
    end
    chk("ar_wrreq_before", 32'(fifo_wrreq), 32'd1);
    #5 rst_n = 1'b0;
    #1;
    chk("ar_wrreq", 32'(fifo_wrreq), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(capture_done), 32'd0);
    chk("ar_data", 32'(fifo_data), 32'd0);
    chk("ar_sample_cnt", 32'(sample_cnt), 32'd0);
    chk("ar_overflow_cnt", 32'(overflow_cnt), 32'd0);
    base_w = wr_q.size();
    repeat (3) @(negedge clk_50M);
    rst_n = 1'b1;
    repeat (10) @(negedge clk_50M);
    adc_valid = 1'b0;
    chk("ar_no_writes", 32'(wr_q.size() - base_w), 32'd0);
    chk("ar_busy_after", 32'(busy), 32'd0);
    chk("ar_sample_cnt_after", 32'(sample_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
